// File: rtl/game_pkg.sv
// Shared types, colour constants and the box-overlap test for the game core.
package game_pkg;

    typedef enum logic [1:0] {
        SCR_START    = 2'd0,
        SCR_PLAY     = 2'd1,
        SCR_GAMEOVER = 2'd2,
        SCR_HIT      = 2'd3
    } screen_e;

    localparam logic [2:0] COLOR_BLACK = 3'd0;

    // Coordinates are zero-extended to 16 bits; sums use 17 bits so nothing wraps.
    function automatic logic box_overlap(
        input logic [15:0] ax,
        input logic [15:0] ay,
        input logic [15:0] aw,
        input logic [15:0] ah,
        input logic [15:0] bx,
        input logic [15:0] by,
        input logic [15:0] bw,
        input logic [15:0] bh
    );
        logic ov_x;
        logic ov_y;
        ov_x = ({1'b0, ax} + {1'b0, aw} > {1'b0, bx})
            && ({1'b0, bx} + {1'b0, bw} > {1'b0, ax});
        ov_y = ({1'b0, ay} + {1'b0, ah} > {1'b0, by})
            && ({1'b0, by} + {1'b0, bh} > {1'b0, ay});
        return ov_x && ov_y;
    endfunction

endpackage

// File: rtl/game_core_bcd_counter.sv
// Saturating multi-digit BCD counter with synchronous clear and increment.
module bcd_counter
    import game_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   q
);

    logic [4*DIGITS-1:0] cnt_q;
    logic [4*DIGITS-1:0] cnt_d;
    logic                all_nine;
    logic                carry;

    always_comb begin
        cnt_d    = cnt_q;
        carry    = 1'b1;
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_nine = all_nine && (cnt_q[4*i +: 4] == 4'd9);
        end
        if (clr) begin
            cnt_d = '0;
        end else if (en && !all_nine) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] == 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/game_core.sv
// Multi-ghost game logic: screen FSM, score/lives, collisions and pixel compositing.
module game_core
    import game_pkg::*;
#(
    parameter int N_GHOSTS     = 4,
    parameter int SPRITE_W     = 4,
    parameter int SPRITE_H     = 4,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int SCORE_DIGITS = 2,
    parameter int LIVES        = 3,
    parameter int HIT_FRAMES   = 8
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      startGame,
    input  logic                      frame_tick,
    input  logic [X_W-1:0]            player_x,
    input  logic [Y_W-1:0]            player_y,
    input  logic [N_GHOSTS*X_W-1:0]   ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0]   ghost_y,
    input  logic [N_GHOSTS-1:0]       ghost_valid,
    input  logic [N_GHOSTS-1:0]       ghost_bad,
    input  logic                      wall_hit,
    input  logic                      pix_en,
    input  logic [X_W-1:0]            x_vga,
    input  logic [Y_W-1:0]            y_vga,
    input  logic [2:0]                sprite_color,
    input  logic [2:0]                background_color,
    input  logic [2:0]                startscreen_color,
    input  logic [2:0]                gameover_color,
    input  logic [N_GHOSTS*3-1:0]     ghost_color,
    output logic [2:0]                color_vga,
    output logic [1:0]                s_screen,
    output logic [N_GHOSTS-1:0]       ghost_respawn,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [2:0]                lives,
    output logic                      s_game_over,
    output logic                      collisionDetect
);

    localparam int HCW = $clog2(HIT_FRAMES + 1);

    screen_e             scr_q, scr_d;
    logic [HCW-1:0]      hit_cnt_q, hit_cnt_d;
    logic [2:0]          lives_q, lives_d;
    logic [N_GHOSTS-1:0] respawn_q, respawn_d;
    logic                game_over_q, game_over_d;
    logic                coll_q, coll_d;
    logic [2:0]          color_q, color_d;
    logic                score_clr, score_inc;

    logic [N_GHOSTS-1:0] ghost_ov, ghost_pix;
    logic [N_GHOSTS-1:0] bad_ov, good_ov;
    logic [N_GHOSTS-1:0] bad_sel, good_sel, pix_sel;
    logic [2:0]          ghost_col;
    logic                player_pix;

    for (genvar i = 0; i < N_GHOSTS; i++) begin : g_ghost
        logic [X_W-1:0] gx;
        logic [Y_W-1:0] gy;
        assign gx = ghost_x[X_W*i +: X_W];
        assign gy = ghost_y[Y_W*i +: Y_W];
        assign ghost_ov[i] = ghost_valid[i] & box_overlap(
            16'(player_x), 16'(player_y), 16'(SPRITE_W), 16'(SPRITE_H),
            16'(gx), 16'(gy), 16'(SPRITE_W), 16'(SPRITE_H));
        assign ghost_pix[i] = ghost_valid[i] & box_overlap(
            16'(x_vga), 16'(y_vga), 16'd1, 16'd1,
            16'(gx), 16'(gy), 16'(SPRITE_W), 16'(SPRITE_H));
    end

    assign player_pix = box_overlap(
        16'(x_vga), 16'(y_vga), 16'd1, 16'd1,
        16'(player_x), 16'(player_y), 16'(SPRITE_W), 16'(SPRITE_H));

    // x & -x isolates the lowest set bit: lowest index wins.
    assign bad_ov   = ghost_ov & ghost_bad;
    assign good_ov  = ghost_ov & ~ghost_bad;
    assign bad_sel  = bad_ov & (~bad_ov + N_GHOSTS'(1));
    assign good_sel = good_ov & (~good_ov + N_GHOSTS'(1));
    assign pix_sel  = ghost_pix & (~ghost_pix + N_GHOSTS'(1));

    always_comb begin
        ghost_col = COLOR_BLACK;
        for (int i = 0; i < N_GHOSTS; i++) begin
            if (pix_sel[i]) ghost_col = ghost_color[3*i +: 3];
        end
    end

    always_comb begin
        scr_d     = scr_q;
        hit_cnt_d = hit_cnt_q;
        lives_d   = lives_q;
        respawn_d = '0;
        coll_d    = coll_q;
        score_clr = 1'b0;
        score_inc = 1'b0;
        if (frame_tick) begin
            coll_d = (scr_q == SCR_PLAY) && wall_hit;
            unique case (scr_q)
                SCR_START: begin
                    if (startGame) begin
                        scr_d     = SCR_PLAY;
                        lives_d   = 3'(LIVES);
                        respawn_d = '1;
                        score_clr = 1'b1;
                    end
                end
                SCR_PLAY: begin
                    if ((|bad_ov) || wall_hit) begin
                        lives_d   = lives_q - 3'd1;
                        respawn_d = bad_sel;
                        if (lives_q == 3'd1) begin
                            scr_d = SCR_GAMEOVER;
                        end else begin
                            scr_d     = SCR_HIT;
                            hit_cnt_d = HCW'(HIT_FRAMES);
                        end
                    end else if (|good_ov) begin
                        score_inc = 1'b1;
                        respawn_d = good_sel;
                    end
                end
                SCR_HIT: begin
                    hit_cnt_d = hit_cnt_q - HCW'(1);
                    if (hit_cnt_q <= HCW'(1)) begin
                        hit_cnt_d = '0;
                        scr_d     = SCR_PLAY;
                    end
                end
                SCR_GAMEOVER: begin
                    if (startGame) scr_d = SCR_START;
                end
            endcase
        end
        game_over_d = (scr_d == SCR_GAMEOVER);
    end

    // Compositing looks at the pre-update state so a coincident tick has no effect.
    always_comb begin
        color_d = color_q;
        if (pix_en) begin
            if (scr_q == SCR_START) begin
                color_d = startscreen_color;
            end else if (scr_q == SCR_GAMEOVER) begin
                color_d = gameover_color;
            end else if (player_pix
                         && !(scr_q == SCR_HIT && hit_cnt_q[0])) begin
                color_d = sprite_color;
            end else if (|ghost_pix) begin
                color_d = ghost_col;
            end else begin
                color_d = background_color;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            scr_q       <= SCR_START;
            hit_cnt_q   <= '0;
            lives_q     <= 3'(LIVES);
            respawn_q   <= '0;
            game_over_q <= 1'b0;
            coll_q      <= 1'b0;
            color_q     <= COLOR_BLACK;
        end else begin
            scr_q       <= scr_d;
            hit_cnt_q   <= hit_cnt_d;
            lives_q     <= lives_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            coll_q      <= coll_d;
            color_q     <= color_d;
        end
    end

    bcd_counter #(
        .DIGITS(SCORE_DIGITS)
    ) u_score (
        .clk (CLOCK_50),
        .rst (reset),
        .clr (score_clr),
        .en  (score_inc),
        .q   (score_bcd)
    );

    assign color_vga       = color_q;
    assign s_screen        = scr_q;
    assign ghost_respawn   = respawn_q;
    assign lives           = lives_q;
    assign s_game_over     = game_over_q;
    assign collisionDetect = coll_q;

endmodule

// File: tb/tb_game_core.sv
// Directed self-checking bench for game_core with default parameters.
module tb_game_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        startGame;
    logic        frame_tick;
    logic [7:0]  player_x;
    logic [6:0]  player_y;
    logic [31:0] ghost_x;
    logic [27:0] ghost_y;
    logic [3:0]  ghost_valid;
    logic [3:0]  ghost_bad;
    logic        wall_hit;
    logic        pix_en;
    logic [7:0]  x_vga;
    logic [6:0]  y_vga;
    logic [2:0]  sprite_color;
    logic [2:0]  background_color;
    logic [2:0]  startscreen_color;
    logic [2:0]  gameover_color;
    logic [11:0] ghost_color;
    logic [2:0]  color_vga;
    logic [1:0]  s_screen;
    logic [3:0]  ghost_respawn;
    logic [7:0]  score_bcd;
    logic [2:0]  lives;
    logic        s_game_over;
    logic        collisionDetect;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_core dut (
        .CLOCK_50          (clk),
        .reset             (reset),
        .startGame         (startGame),
        .frame_tick        (frame_tick),
        .player_x          (player_x),
        .player_y          (player_y),
        .ghost_x           (ghost_x),
        .ghost_y           (ghost_y),
        .ghost_valid       (ghost_valid),
        .ghost_bad         (ghost_bad),
        .wall_hit          (wall_hit),
        .pix_en            (pix_en),
        .x_vga             (x_vga),
        .y_vga             (y_vga),
        .sprite_color      (sprite_color),
        .background_color  (background_color),
        .startscreen_color (startscreen_color),
        .gameover_color    (gameover_color),
        .ghost_color       (ghost_color),
        .color_vga         (color_vga),
        .s_screen          (s_screen),
        .ghost_respawn     (ghost_respawn),
        .score_bcd         (score_bcd),
        .lives             (lives),
        .s_game_over       (s_game_over),
        .collisionDetect   (collisionDetect)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ghost(input int i, input logic [7:0] x,
                             input logic [6:0] y);
        ghost_x[8*i +: 8] = x;
        ghost_y[7*i +: 7] = y;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic pixel(input logic [7:0] x, input logic [6:0] y);
        x_vga  = x;
        y_vga  = y;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_scr"}, 32'(s_screen), 32'd0);
        chk({tag, "_col"}, 32'(color_vga), 32'd0);
        chk({tag, "_score"}, 32'(score_bcd), 32'h00);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_resp"}, 32'(ghost_respawn), 32'h0);
        chk({tag, "_go"}, 32'(s_game_over), 32'd0);
        chk({tag, "_coll"}, 32'(collisionDetect), 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        startGame         = 1'b0;
        frame_tick        = 1'b0;
        player_x          = 8'd20;
        player_y          = 7'd20;
        ghost_x           = '0;
        ghost_y           = '0;
        ghost_valid       = 4'b1111;
        ghost_bad         = 4'b0011;
        wall_hit          = 1'b0;
        pix_en            = 1'b0;
        x_vga             = '0;
        y_vga             = '0;
        sprite_color      = 3'd5;
        background_color  = 3'd6;
        startscreen_color = 3'd7;
        gameover_color    = 3'd2;
        ghost_color       = {3'd1, 3'd1, 3'd4, 3'd3};
        set_ghost(0, 8'd100, 7'd100);
        set_ghost(1, 8'd120, 7'd100);
        set_ghost(2, 8'd100, 7'd50);
        set_ghost(3, 8'd60, 7'd60);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        chk_reset_state("rst");

        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        chk("start_scr", 32'(s_screen), 32'd1);
        chk("start_lives", 32'(lives), 32'd3);
        chk("start_score", 32'(score_bcd), 32'h00);
        chk("start_resp", 32'(ghost_respawn), 32'hF);
        idle();
        chk("start_resp_pulse", 32'(ghost_respawn), 32'h0);

        set_ghost(2, 8'd24, 7'd20);
        tick();
        chk("edge_right_score", 32'(score_bcd), 32'h00);
        chk("edge_right_resp", 32'(ghost_respawn), 32'h0);
        set_ghost(2, 8'd16, 7'd20);
        tick();
        chk("edge_left_score", 32'(score_bcd), 32'h00);

        set_ghost(2, 8'd23, 7'd23);
        tick();
        chk("good_resp", 32'(ghost_respawn), 32'h4);
        repeat (11) tick();
        chk("score_12", 32'(score_bcd), 32'h12);
        chk("play_scr", 32'(s_screen), 32'd1);
        repeat (90) tick();
        chk("score_sat", 32'(score_bcd), 32'h99);

        ghost_bad = 4'b0001;
        set_ghost(0, 8'd20, 7'd20);
        set_ghost(1, 8'd21, 7'd21);
        set_ghost(2, 8'd100, 7'd50);
        tick();
        chk("bad_lives", 32'(lives), 32'd2);
        chk("bad_resp", 32'(ghost_respawn), 32'h1);
        chk("bad_score", 32'(score_bcd), 32'h99);
        chk("bad_scr", 32'(s_screen), 32'd3);
        pixel(8'd21, 7'd21);
        chk("hit_even_pix", 32'(color_vga), 32'd5);
        tick();
        pixel(8'd21, 7'd21);
        chk("hit_odd_pix", 32'(color_vga), 32'd3);
        chk("hit_lives_held", 32'(lives), 32'd2);
        repeat (6) tick();
        chk("hit_7_scr", 32'(s_screen), 32'd3);
        x_vga  = 8'd21;
        y_vga  = 7'd21;
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        chk("hit_8_scr", 32'(s_screen), 32'd1);
        chk("coincide_pix", 32'(color_vga), 32'd3);

        pixel(8'd21, 7'd21);
        chk("play_player_pix", 32'(color_vga), 32'd5);
        pixel(8'd24, 7'd24);
        chk("play_ghost1_pix", 32'(color_vga), 32'd4);
        pixel(8'd0, 7'd0);
        chk("play_bg_pix", 32'(color_vga), 32'd6);
        x_vga = 8'd21;
        y_vga = 7'd21;
        idle();
        chk("pix_hold", 32'(color_vga), 32'd6);

        tick();
        chk("loss2_lives", 32'(lives), 32'd1);
        chk("loss2_scr", 32'(s_screen), 32'd3);
        repeat (8) tick();
        chk("loss2_back", 32'(s_screen), 32'd1);
        ghost_valid = 4'b1110;
        wall_hit    = 1'b1;
        tick();
        wall_hit    = 1'b0;
        chk("go_scr", 32'(s_screen), 32'd2);
        chk("go_flag", 32'(s_game_over), 32'd1);
        chk("go_lives", 32'(lives), 32'd0);
        chk("go_resp", 32'(ghost_respawn), 32'h0);
        chk("go_score", 32'(score_bcd), 32'h99);
        chk("go_coll", 32'(collisionDetect), 32'd1);
        pixel(8'd21, 7'd21);
        chk("go_pix", 32'(color_vga), 32'd2);
        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        chk("restart_scr", 32'(s_screen), 32'd0);
        chk("restart_go", 32'(s_game_over), 32'd0);
        pixel(8'd21, 7'd21);
        chk("start_pix", 32'(color_vga), 32'd7);

        startGame = 1'b1;
        tick();
        startGame = 1'b0;
        chk("replay_lives", 32'(lives), 32'd3);
        chk("replay_score", 32'(score_bcd), 32'h00);
        wall_hit = 1'b1;
        x_vga    = 8'd0;
        y_vga    = 7'd0;
        pix_en   = 1'b1;
        tick();
        wall_hit = 1'b0;
        pix_en   = 1'b0;
        chk("wall_scr", 32'(s_screen), 32'd3);
        chk("wall_lives", 32'(lives), 32'd2);
        chk("wall_score", 32'(score_bcd), 32'h00);
        chk("wall_pix", 32'(color_vga), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("midhit");
        idle();
        reset = 1'b0;
        idle();
        chk_reset_state("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
